// File: rtl/seg_capture_decode.sv
// seg_capture_decode
// Captures a multiplexed 4-digit, active-low 7-segment display.
// The inputs are sampled once per cycle. A digit is accepted after its sample
// has been stable for STABLE_CYCLES edges. A frame is published once all four
// digit positions have been captured.
module seg_capture_decode #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg,
   input  logic [3:0]  dig,
   output logic [15:0] value,
   output logic        valid,
   output logic        err,
   output logic        digerr
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   // Segment pattern -> {invalid, nibble}; unknown patterns decode to 4'h0 with invalid set
   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1000000: r = 5'h00;
         7'b1111001: r = 5'h01;
         7'b0100100: r = 5'h02;
         7'b0110000: r = 5'h03;
         7'b0011001: r = 5'h04;
         7'b0010010: r = 5'h05;
         7'b0000010: r = 5'h06;
         7'b1111000: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0010000: r = 5'h09;
         7'b0001000: r = 5'h0A;
         7'b0000011: r = 5'h0B;
         7'b1000110: r = 5'h0C;
         7'b0100001: r = 5'h0D;
         7'b0000110: r = 5'h0E;
         7'b0001110: r = 5'h0F;
         default:    r = 5'h10;
      endcase
      return r;
   endfunction

   // Number of active (low) digit enables
   function automatic logic [2:0] low_count(input logic [3:0] d);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 4; i++) begin
         c = c + {2'b00, ~d[i]};
      end
      return c;
   endfunction

   logic [6:0]  s_seg_r;
   logic [3:0]  s_dig_r;
   logic [7:0]  cnt_r;
   logic        accepted_r;
   logic [3:0]  mask_r;
   logic [15:0] shadow_r;
   logic        ferr_r;
   logic [15:0] value_r;
   logic        valid_r;
   logic        err_r;
   logic        digerr_r;

   logic        same_s;
   logic [7:0]  cnt_next_s;
   logic        accept_s;
   logic [4:0]  dec_s;
   logic        one_hot_s;
   logic        multi_s;
   logic [3:0]  mask_new_s;
   logic [15:0] shadow_new_s;
   logic        frame_done_s;

   // Stability tracking, acceptance decision and the would-be shadow/mask update
   always_comb begin
      same_s       = ({seg, dig} == {s_seg_r, s_dig_r});
      cnt_next_s   = 8'd0;
      accept_s     = 1'b0;
      dec_s        = seg_decode(s_seg_r);
      one_hot_s    = 1'b0;
      multi_s      = (low_count(s_dig_r) >= 3'd2);
      mask_new_s   = mask_r | ~s_dig_r;
      shadow_new_s = shadow_r;
      frame_done_s = 1'b0;

      if (same_s) begin
         if (cnt_r >= CNT_MAX) begin
            cnt_next_s = CNT_MAX;
         end else begin
            cnt_next_s = cnt_r + 8'd1;
         end
      end else begin
         cnt_next_s = 8'd0;
      end

      accept_s = same_s && (cnt_next_s == CNT_MAX) && !accepted_r;

      case (s_dig_r)
         4'b1110: begin one_hot_s = 1'b1; shadow_new_s[3:0]   = dec_s[3:0]; end
         4'b1101: begin one_hot_s = 1'b1; shadow_new_s[7:4]   = dec_s[3:0]; end
         4'b1011: begin one_hot_s = 1'b1; shadow_new_s[11:8]  = dec_s[3:0]; end
         4'b0111: begin one_hot_s = 1'b1; shadow_new_s[15:12] = dec_s[3:0]; end
         default: begin one_hot_s = 1'b0; end
      endcase

      frame_done_s = accept_s && one_hot_s && (mask_new_s == 4'hF);
   end

   // Sample register, stability counter, frame assembly and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         s_seg_r    <= 7'h7F;
         s_dig_r    <= 4'hF;
         cnt_r      <= 8'd0;
         accepted_r <= 1'b0;
         mask_r     <= 4'h0;
         shadow_r   <= 16'h0000;
         ferr_r     <= 1'b0;
         value_r    <= 16'h0000;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
         digerr_r   <= 1'b0;
      end else begin
         s_seg_r <= seg;
         s_dig_r <= dig;
         cnt_r   <= cnt_next_s;
         valid_r <= 1'b0;
         err_r   <= 1'b0;

         if (!same_s) begin
            accepted_r <= 1'b0;
         end else if (accept_s) begin
            accepted_r <= 1'b1;
         end else begin
            accepted_r <= accepted_r;
         end

         if (accept_s && one_hot_s) begin
            shadow_r <= shadow_new_s;
            if (frame_done_s) begin
               value_r <= shadow_new_s;
               valid_r <= 1'b1;
               err_r   <= ferr_r | dec_s[4];
               mask_r  <= 4'h0;
               ferr_r  <= 1'b0;
            end else begin
               mask_r  <= mask_new_s;
               ferr_r  <= ferr_r | dec_s[4];
            end
         end else begin
            shadow_r <= shadow_r;
         end

         if (accept_s && multi_s) begin
            digerr_r <= 1'b1;
         end else begin
            digerr_r <= digerr_r;
         end
      end
   end

   assign value  = value_r;
   assign valid  = valid_r;
   assign err    = err_r;
   assign digerr = digerr_r;

endmodule

// File: tb/tb_seg_capture_decode.sv
// Testbench for seg_capture_decode: a behavioural reference model, directed
// scenarios and randomized dwells, with a per-cycle compare.
module tb_seg_capture_decode;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [3:0]  dig;
   logic [15:0] value;
   logic        valid;
   logic        err;
   logic        digerr;

   always #5 clk = ~clk;

   seg_capture_decode #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .seg(seg), .dig(dig),
      .value(value), .valid(valid), .err(err), .digerr(digerr)
   );

   int nvec  = 0;
   int nfail = 0;
   int obs_valid = 0;
   int obs_err   = 0;

   logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // reference model state
   logic [6:0]  m_seg = 7'h7F;
   logic [3:0]  m_dig = 4'hF;
   int          run_len = 1;
   logic [3:0]  m_nib [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0]  m_have = 4'h0;
   logic        m_ferr = 1'b0;
   logic [15:0] e_value = 16'h0;
   logic        e_valid = 1'b0, e_err = 1'b0, e_digerr = 1'b0;

   function automatic int lookup(input logic [6:0] p);
      for (int k = 0; k < 16; k++) if (pat[k] == p) return k;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a digit counts once its sample has been identical for SC edges in a row
   task automatic model_step(input logic [6:0] sg, input logic [3:0] dg, input logic rs);
      int zeros, idx, k;
      if (rs) begin
         m_seg = 7'h7F; m_dig = 4'hF; run_len = 1;
         for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
         m_have = 4'h0; m_ferr = 1'b0;
         e_value = 16'h0; e_valid = 1'b0; e_err = 1'b0; e_digerr = 1'b0;
         return;
      end
      if (sg == m_seg && dg == m_dig) run_len++;
      else run_len = 1;
      m_seg = sg; m_dig = dg;
      e_valid = 1'b0; e_err = 1'b0;
      if (run_len == SC) begin
         zeros = 0; idx = 0;
         for (int i = 0; i < 4; i++) if (!m_dig[i]) begin zeros++; idx = i; end
         if (zeros == 1) begin
            k = lookup(m_seg);
            m_nib[idx] = (k < 0) ? 4'h0 : 4'(k);
            if (k < 0) m_ferr = 1'b1;
            m_have[idx] = 1'b1;
            if (m_have == 4'hF) begin
               e_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
               e_valid = 1'b1; e_err = m_ferr;
               m_have = 4'h0; m_ferr = 1'b0;
            end
         end else if (zeros >= 2) begin
            e_digerr = 1'b1;
         end
      end
   endtask

   // Drive one input value for n cycles; model on the rising edge, compare on the falling edge
   task automatic cyc(input logic [6:0] sg, input logic [3:0] dg, input logic rs, input int n);
      for (int i = 0; i < n; i++) begin
         reset = rs; seg = sg; dig = dg;
         @(posedge clk);
         model_step(sg, dg, rs);
         @(negedge clk);
         chk("value",  value,  e_value);
         chk("valid",  {15'd0, valid},  {15'd0, e_valid});
         chk("err",    {15'd0, err},    {15'd0, e_err});
         chk("digerr", {15'd0, digerr}, {15'd0, e_digerr});
         obs_valid += int'(valid);
         obs_err   += int'(err);
      end
   endtask

   task automatic frame4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
      cyc(p0, 4'b1110, 1'b0, 6);
      cyc(p1, 4'b1101, 1'b0, 6);
      cyc(p2, 4'b1011, 1'b0, 6);
      cyc(p3, 4'b0111, 1'b0, 6);
   endtask

   initial begin
      logic [6:0] rs_seg;
      logic [3:0] rs_dig;
      int         r;
      reset = 1'b1; seg = 7'h7F; dig = 4'hF;
      @(negedge clk);
      cyc(7'h7F, 4'hF, 1'b1, 2);
      chk("reset_value",  value, 16'h0000);
      chk("reset_digerr", {15'd0, digerr}, 16'h0000);

      // basic frame D,7,5,1
      obs_valid = 0; obs_err = 0;
      frame4(7'b0100001, 7'b1111000, 7'b0010010, 7'b1111001);
      chk("t26_value",  value, 16'h157D);
      chk("t26_pulses", 16'(obs_valid), 16'd1);
      chk("t26_err",    16'(obs_err), 16'd0);

      // glitch on digit 2 rejected, E accepted
      obs_valid = 0; obs_err = 0;
      cyc(7'b0100001, 4'b1110, 1'b0, 6);
      cyc(7'b1111000, 4'b1101, 1'b0, 6);
      cyc(7'b0010010, 4'b1011, 1'b0, 3);
      cyc(7'b0000110, 4'b1011, 1'b0, 4);
      cyc(7'b1111001, 4'b0111, 1'b0, 6);
      chk("t27_value",  value, 16'h1E7D);
      chk("t27_pulses", 16'(obs_valid), 16'd1);

      // invalid digit 1
      obs_valid = 0; obs_err = 0;
      frame4(7'b0100001, 7'b1111111, 7'b0010010, 7'b1111001);
      chk("t28_value",  value, 16'h150D);
      chk("t28_pulses", 16'(obs_valid), 16'd1);
      chk("t28_err",    16'(obs_err), 16'd1);

      // two digits enabled at once
      obs_valid = 0;
      cyc(7'b1000000, 4'b1100, 1'b0, 10);
      chk("t29_digerr", {15'd0, digerr}, 16'h0001);
      cyc(7'b0010010, 4'b1011, 1'b0, 6);
      cyc(7'b1111001, 4'b0111, 1'b0, 6);
      chk("t29_mask_kept", 16'(obs_valid), 16'd0);
      cyc(7'b0100001, 4'b1110, 1'b0, 6);
      cyc(7'b1111000, 4'b1101, 1'b0, 6);
      chk("t29_frame", 16'(obs_valid), 16'd1);
      chk("t29_sticky", {15'd0, digerr}, 16'h0001);
      cyc(7'h7F, 4'hF, 1'b1, 1);
      chk("t29_cleared", {15'd0, digerr}, 16'h0000);

      // reset mid-frame
      obs_valid = 0;
      cyc(7'b0100001, 4'b1110, 1'b0, 6);
      cyc(7'b1111000, 4'b1101, 1'b0, 6);
      cyc(7'b0010010, 4'b1011, 1'b0, 6);
      cyc(7'h7F, 4'hF, 1'b1, 1);
      cyc(7'b1111001, 4'b0111, 1'b0, 6);
      chk("t30_novalid", 16'(obs_valid), 16'd0);
      chk("t30_value",   value, 16'h0000);
      frame4(7'b0100001, 7'b1111000, 7'b0010010, 7'b1111001);
      chk("t30_after", value, 16'h157D);
      chk("t30_pulses", 16'(obs_valid), 16'd1);

      // long dwell and rewrite
      obs_valid = 0;
      cyc(7'b0100001, 4'b1110, 1'b0, 40);
      cyc(7'b1111000, 4'b1101, 1'b0, 6);
      cyc(7'b0100100, 4'b1110, 1'b0, 6);
      cyc(7'b0010010, 4'b1011, 1'b0, 6);
      cyc(7'b1111001, 4'b0111, 1'b0, 6);
      chk("t31_value",  value, 16'h1572);
      chk("t31_pulses", 16'(obs_valid), 16'd1);

      // randomized dwells
      for (int it = 0; it < 300; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 80) rs_seg = pat[$urandom_range(0, 15)];
         else        rs_seg = 7'($urandom);
         r = int'($urandom_range(0, 99));
         if (r < 65)      rs_dig = ~(4'b0001 << $urandom_range(0, 3));
         else if (r < 85) rs_dig = 4'hF;
         else             rs_dig = 4'($urandom);
         r = int'($urandom_range(0, 99));
         cyc(rs_seg, rs_dig, (r < 2) ? 1'b1 : 1'b0, int'($urandom_range(1, 8)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/seg_capture_decode.md
SEG_CAPTURE_DECODE -- requirements
Module: seg_capture_decode

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical registered samples required before a digit is accepted; legal range 2..255.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 SEG  input  7  active-low segment lines, bit0=a .. bit6=g.
REQ-005 DIG  input  4  active-low digit enables of a multiplexed 4-digit display; DIG[i]=0 selects digit i (digit 0 = least significant nibble).
REQ-006 VALUE  output  16  last completed frame, digit i in VALUE[4i+3:4i].
REQ-007 VALID  output  1  one-cycle pulse, frame completed and VALUE updated.
REQ-008 ERR  output  1  one-cycle pulse coincident with VALID, at least one digit in that frame had an undecodable pattern.
REQ-009 DIGERR  output  1  sticky flag, a stable DIG with more than one bit low was seen; cleared only by RESET.

Function
REQ-010 SEG and DIG shall be registered once (sample register S) every cycle; all further logic shall use S only.
REQ-011 Decode table (SEG -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-012 Any SEG pattern not in REQ-011 shall be invalid: nibble stored as 4'h0 and the frame's error bit set.
REQ-013 Stability counter CNT (8 bit): S unchanged vs previous cycle -> CNT increments, saturating at STABLE_CYCLES-1; S changed -> CNT=0.
REQ-014 Accept condition: CNT reaches STABLE_CYCLES-1 on this edge and a per-dwell ACCEPTED flag is clear; ACCEPTED then sets and clears only when S changes, so one dwell yields at most one acceptance.
REQ-015 Timing: value presented at ports before edge k and held -> S valid after edge k -> acceptance at edge k+STABLE_CYCLES-1.
REQ-016 On acceptance with exactly one DIG bit low (digit i): nibble i of shadow register written, mask bit i set, error bit OR-ed per REQ-012.
REQ-017 Re-acceptance of a digit already in the mask shall overwrite its nibble; mask unchanged; error bit remains set if previously set.
REQ-018 On acceptance with DIG=4'hF (blank): no capture, no mask change.
REQ-019 On acceptance with two or more DIG bits low: no capture, DIGERR set.
REQ-020 When an acceptance makes mask=4'hF: on that same edge VALUE <= shadow including the new nibble, VALID=1 and ERR=frame error bit for the following cycle, mask and frame error bit cleared.
REQ-021 VALUE shall hold between frames; VALID and ERR shall be 0 in all other cycles.
REQ-022 Digit order within a frame is arbitrary; no timeout; a partial frame persists indefinitely.

Reset
REQ-023 RESET=1 at an edge: VALUE=16'h0000, VALID=0, ERR=0, DIGERR=0, mask=0, shadow=0, frame error=0, CNT=0, ACCEPTED=0, S=blank (SEG=7'h7F, DIG=4'hF).
REQ-024 RESET mid-frame discards the partial frame; the next frame requires all four digits anew.
REQ-025 RESET has priority over acceptance and frame completion on the same edge.

Verification
REQ-026 STABLE_CYCLES=4; digits 0..3 driven with 7'b0100001, 7'b1111000, 7'b0010010, 7'b1111001 each for 6 cycles -> single VALID pulse, VALUE=16'h157D, ERR=0.
REQ-027 Digit 2 pattern held only 3 cycles, then 7'b0000110 for 4 cycles -> glitch rejected, nibble 2 = E after full frame.
REQ-028 Digit 1 driven with 7'b1111111 (invalid), others valid -> VALID and ERR pulse together, VALUE[7:4]=0.
REQ-029 DIG=4'b1100 held 10 cycles -> DIGERR=1, mask unchanged, no VALID; DIGERR stays 1 until RESET.
REQ-030 Three digits captured, RESET for 1 cycle, fourth digit captured -> no VALID, VALUE=0; full frame afterwards completes normally.
REQ-031 Same digit 0 held 40 cycles -> exactly one acceptance; digit 0 rewritten with new pattern before frame end -> completed VALUE carries newest nibble.
